// File: rtl/mod_n_pkg.sv
// Shared definitions for the mod-N down counter.
//   state_t       : control FSM encoding (IDLE / COUNT / PAUSE)
//   width_for()   : smallest counter width able to hold 0..n-1
//   DEFAULT_N / DEFAULT_WIDTH : the standard tick-divider configuration
package mod_n_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    PAUSE = 2'b10
  } state_t;

  function automatic int width_for(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_N     = 10;
  localparam int DEFAULT_WIDTH = width_for(DEFAULT_N);

endpackage

// File: rtl/mod_n_down_counter_if.sv
// Control/status bundle of the mod-N down counter.
//   start, stop, en, load, load_val : commands from the controlling block
//   out, tc, busy                   : registered counter status
//   state                           : current FSM state, for observation
// There is no valid/ready pairing here: every command is a level sampled
// on each rising clock edge, and every status output is valid right after
// that edge. The command side never stalls.
interface mod_n_down_counter_if
  import mod_n_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic             stop;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;
  state_t           state;

  modport master (
    output start, stop, en, load, load_val,
    input  out, tc, busy, state
  );

  modport slave (
    input  start, stop, en, load, load_val,
    output out, tc, busy, state
  );

endinterface

// File: rtl/mod_n_ctrl_fsm.sv
// Start/stop/pause control for the mod-N down counter.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   start, stop, en  : control commands
//   load             : parallel-load strobe (blocks counting this cycle)
//   zero             : counter currently at 0
//   state            : current FSM state
//   busy             : registered, high in COUNT or PAUSE
//   dec              : datapath should count this cycle
//   wrap             : datapath should reload N-1 and pulse tc
// Build option MOD_N_ONESHOT_EN: reaching zero while counting returns the
// FSM to IDLE instead of wrapping around.
module mod_n_ctrl_fsm
  import mod_n_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   start,
  input  logic   stop,
  input  logic   en,
  input  logic   load,
  input  logic   zero,
  output state_t state,
  output logic   busy,
  output logic   dec,
  output logic   wrap
);

  state_t next_state;

  // Load outranks everything but reset; it still honours a simultaneous
  // stop, but otherwise leaves the state untouched.
  always_comb begin
    next_state = state;
    if (load || stop) begin
      if (stop) next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) next_state = COUNT;
        COUNT: begin
          if (!en) next_state = PAUSE;
`ifdef MOD_N_ONESHOT_EN
          else if (zero) next_state = IDLE;
`endif
        end
        PAUSE: if (en) next_state = COUNT;
        default: next_state = IDLE;
      endcase
    end
  end

  // busy follows the next state so it rises on the edge entering COUNT.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  assign dec  = (state == COUNT) && en && !load && !stop;
  assign wrap = dec && zero;

endmodule

// File: rtl/mod_n_down_counter.sv
// Programmable modulo-N down counter: counts N-1 down to 0, then reloads
// N-1 with a one-cycle terminal-count pulse. Start/stop/pause control lives
// in mod_n_ctrl_fsm; this module holds the count datapath.
// Parameters: N (modulus, >= 2), WIDTH (2**WIDTH >= N).
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset (out=N-1, tc=0, busy=0, IDLE)
//   bus  : mod_n_down_counter_if.slave (commands in, out/tc/busy/state out)
// Build option MOD_N_ONESHOT_EN: one pass N-1..0, then reload N-1, pulse
// tc and return to IDLE.
module mod_n_down_counter
  import mod_n_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic rstn,
  mod_n_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(N - 1);
  // One extra bit so the compare still works when N == 2**WIDTH.
  localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);

  logic [WIDTH-1:0] out_q;
  logic             tc_q;
  logic [WIDTH-1:0] load_clamped;
  logic             zero;
  logic             dec;
  logic             wrap;
  logic             busy;
  state_t           state;

  assign load_clamped = ({1'b0, bus.load_val} >= N_EXT) ? LAST : bus.load_val;
  assign zero         = (out_q == '0);

  mod_n_ctrl_fsm u_ctrl (
    .clk   (clk),
    .rstn  (rstn),
    .start (bus.start),
    .stop  (bus.stop),
    .en    (bus.en),
    .load  (bus.load),
    .zero  (zero),
    .state (state),
    .busy  (busy),
    .dec   (dec),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q <= LAST;
      tc_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        out_q <= load_clamped;
      end else if (wrap) begin
        out_q <= LAST;
        tc_q  <= 1'b1;
      end else if (dec) begin
        out_q <= out_q - 1'b1;
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy;
  assign bus.state = state;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Testbench for mod_n_down_counter (N=10, WIDTH=4): a hand-written vector
// table, targeted multi-cycle sequences, then randomized commands checked
// against a behavioural model. Honours MOD_N_ONESHOT_EN like the design.
module tb_mod_n_down_counter;
  import mod_n_pkg::*;

  localparam int N = 10;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mod_n_down_counter_if #(.WIDTH(W)) bus ();

  mod_n_down_counter #(.N(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic         rstn, start, stop, en, load;
    logic [W-1:0] load_val;
    logic [W-1:0] exp_out;
    logic         exp_tc, exp_busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic p, logic e, logic l,
                              int lv, int eo, logic et, logic eb);
    vec_t v;
    v.rstn = r; v.start = s; v.stop = p; v.en = e; v.load = l;
    v.load_val = W'(lv); v.exp_out = W'(eo); v.exp_tc = et; v.exp_busy = eb;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  int m_cnt;
  bit m_tc, m_active, m_paused;

  function automatic state_t m_state();
    if (!m_active) return IDLE;
    return m_paused ? PAUSE : COUNT;
  endfunction

  // Applies the rules for one rising edge given the inputs currently driven.
  task automatic model_step();
    m_tc = 1'b0;
    if (!rstn) begin
      m_cnt = N - 1; m_active = 0; m_paused = 0;
    end else if (bus.load) begin
      m_cnt = (int'(bus.load_val) >= N) ? N - 1 : int'(bus.load_val);
      if (bus.stop) begin m_active = 0; m_paused = 0; end
    end else if (bus.stop) begin
      m_active = 0; m_paused = 0;
    end else if (!m_active) begin
      if (bus.start) begin m_active = 1; m_paused = 0; end
    end else if (m_paused) begin
      if (bus.en) m_paused = 0;
    end else if (!bus.en) begin
      m_paused = 1;
    end else begin
      m_tc  = (m_cnt == 0);
      m_cnt = (m_cnt + N - 1) % N;
`ifdef MOD_N_ONESHOT_EN
      if (m_tc) m_active = 0;
`endif
    end
  endtask

  // ---------------- driver / checker helpers ----------------
  task automatic drive(logic r, logic s, logic p, logic e, logic l, logic [W-1:0] lv);
    rstn = r; bus.start = s; bus.stop = p; bus.en = e; bus.load = l; bus.load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int eo, logic et, logic eb);
    checks++;
    if (bus.out !== W'(eo) || bus.tc !== et || bus.busy !== eb) begin
      errors++;
      $display("FAIL %s: got out=%0d tc=%b busy=%b, expected out=%0d tc=%b busy=%b",
               name, bus.out, bus.tc, bus.busy, eo, et, eb);
    end
  endtask

  task automatic check_state(string name, state_t es);
    checks++;
    if (bus.state !== es) begin
      errors++;
      $display("FAIL %s: got state=%0d, expected state=%0d", name, bus.state, es);
    end
  endtask

  vec_t vecs[25];

  initial begin
    drive(0, 0, 0, 0, 0, '0);

    // rstn start stop en load lv | out tc busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,  9, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,  9, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 0, 0,  9, 0, 0);  // IDLE holds
    vecs[3]  = mk(1, 1, 0, 1, 0, 0,  9, 0, 1);  // enter COUNT, no decrement
    vecs[4]  = mk(1, 0, 0, 1, 0, 0,  8, 0, 1);
    vecs[5]  = mk(1, 0, 0, 1, 0, 0,  7, 0, 1);
    vecs[6]  = mk(1, 0, 0, 1, 1, 3,  3, 0, 1);  // load at 7
    vecs[7]  = mk(1, 0, 0, 1, 0, 0,  2, 0, 1);
    vecs[8]  = mk(1, 0, 0, 1, 1, 12, 9, 0, 1);  // clamped load, no tc
    vecs[9]  = mk(1, 0, 0, 1, 0, 0,  8, 0, 1);
    vecs[10] = mk(1, 0, 0, 1, 0, 0,  7, 0, 1);
    vecs[11] = mk(1, 0, 0, 1, 0, 0,  6, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 0,  6, 0, 1);  // pause at 6
    vecs[13] = mk(1, 0, 0, 0, 0, 0,  6, 0, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 0,  6, 0, 1);
    vecs[15] = mk(1, 0, 0, 1, 0, 0,  6, 0, 1);  // PAUSE -> COUNT, hold
    vecs[16] = mk(1, 1, 0, 1, 0, 0,  5, 0, 1);  // start ignored in COUNT
    vecs[17] = mk(1, 0, 1, 1, 0, 0,  5, 0, 0);  // stop at 5
    vecs[18] = mk(1, 0, 0, 1, 0, 0,  5, 0, 0);  // IDLE holds
    vecs[19] = mk(1, 0, 1, 1, 1, 2,  2, 0, 0);  // load + stop
    vecs[20] = mk(1, 1, 0, 1, 0, 0,  2, 0, 1);
    vecs[21] = mk(1, 0, 0, 1, 0, 0,  1, 0, 1);
    vecs[22] = mk(1, 0, 0, 1, 0, 0,  0, 0, 1);
`ifdef MOD_N_ONESHOT_EN
    vecs[23] = mk(1, 0, 0, 1, 0, 0,  9, 1, 0);
    vecs[24] = mk(1, 0, 0, 1, 0, 0,  9, 0, 0);
`else
    vecs[23] = mk(1, 0, 0, 1, 0, 0,  9, 1, 1);
    vecs[24] = mk(1, 0, 0, 1, 0, 0,  8, 0, 1);
`endif

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].rstn, vecs[i].start, vecs[i].stop, vecs[i].en,
            vecs[i].load, vecs[i].load_val);
      tick();
      check($sformatf("vec%0d", i), int'(vecs[i].exp_out), vecs[i].exp_tc, vecs[i].exp_busy);
    end
    check_state("vec_end_state", `ifdef MOD_N_ONESHOT_EN IDLE `else COUNT `endif);

    // Reset mid-count at out=4.
    drive(0, 0, 0, 0, 0, '0); tick();
    drive(1, 1, 0, 1, 0, '0); tick();
    drive(1, 0, 0, 1, 0, '0);
    for (int k = 0; k < 5; k++) tick();
    check("pre_reset_at4", 4, 0, 1);
    drive(0, 0, 0, 1, 0, '0); tick();
    check("mid_reset", 9, 0, 0);
    check_state("mid_reset_state", IDLE);

    // Free run (or one-shot pass) from a fresh start.
    drive(1, 1, 0, 1, 0, '0); tick();
    check("run_start", 9, 0, 1);
    drive(1, 0, 0, 1, 0, '0);
    for (int k = 1; k <= 22; k++) begin
      tick();
`ifdef MOD_N_ONESHOT_EN
      if (k < N) check($sformatf("oneshot%0d", k), N - 1 - k, 0, 1);
      else       check($sformatf("oneshot%0d", k), N - 1, (k == N), 0);
`else
      check($sformatf("run%0d", k), (N - 1 - (k % N) + N) % N, (k % N == 0), 1);
`endif
    end

    // Randomized commands against the model.
    drive(0, 0, 0, 0, 0, '0);
    model_step(); tick();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 11) == 0),
            W'($urandom_range(0, (1 << W) - 1)));
      model_step();
      tick();
      check($sformatf("rand%0d", c), m_cnt, m_tc, m_active);
      check_state($sformatf("rand_state%0d", c), m_state());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
